// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory access sequencer, its command
// front-end and the display logic: mode encodings, FSM states and
// default bus widths.
package mem_ctrl_pkg;

  localparam int DEF_ADDR_W = 25;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    CLEAR   = 2'b00,
    READ    = 2'b01,
    WRITE   = 2'b10,
    ILLEGAL = 2'b11
  } mode_e;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_RD   = 3'd2,
    CLR_ISSUE = 3'd3,
    FINISH    = 3'd4
  } state_e;

  // States in which the sequencer is waiting on the memory (timeout applies).
  function automatic logic is_mem_wait(input state_e s);
    return (s == ISSUE) || (s == CLR_ISSUE) || (s == WAIT_RD);
  endfunction

  // States in which a memory request is presented on the bus.
  function automatic logic is_req_state(input state_e s);
    return (s == ISSUE) || (s == CLR_ISSUE);
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Command and memory bus bundle of the memory access sequencer.
// master: the sequencer side; slave: command source plus memory.
interface mem_access_sequencer_if #(
  parameter int ADDR_W = mem_ctrl_pkg::DEF_ADDR_W,
  parameter int DATA_W = mem_ctrl_pkg::DEF_DATA_W
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_mode;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              error;

  modport master (
    input  cmd_valid, cmd_mode, cmd_addr, cmd_wdata,
    input  mem_ack, mem_rvalid, mem_rdata,
    output cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
    output rd_data, done, error
  );

  modport slave (
    output cmd_valid, cmd_mode, cmd_addr, cmd_wdata,
    output mem_ack, mem_rvalid, mem_rdata,
    input  cmd_ready, mem_req, mem_we, mem_addr, mem_wdata,
    input  rd_data, done, error
  );
endinterface

// File: rtl/mem_timeout_cnt.sv
// Wait-cycle counter for the sequencer. Counts enabled cycles since the
// last clear; expired flags the cycle that completes TIMEOUT waiting cycles,
// so the owner can leave its wait state on that same edge.
module mem_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_r;

  // Wait-cycle count; clear has priority so a restart never carries history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (clear) begin
      cnt_r <= '0;
    end else if (enable) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Not gated by clear: the owner's clear depends on its next state, which
  // in turn depends on expired.
  assign expired = enable && (cnt_r == CNT_W'(TIMEOUT - 1));
endmodule

// File: rtl/mem_access_sequencer.sv
// Memory access sequencer: accepts read, write and clear commands from a
// front-end, drives a single-request memory bus, keeps the last read word
// for display and aborts any memory wait that runs past TIMEOUT cycles.
module mem_access_sequencer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int CLEAR_WORDS = 1024,
  parameter int TIMEOUT     = 255
) (
  input logic                    clk,
  input logic                    rst,
  mem_access_sequencer_if.master bus
);
  // One spare bit so CLEAR_WORDS = 2^ADDR_W still fits the word counter.
  localparam int                WCNT_W    = ADDR_W + 1;
  localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(CLEAR_WORDS - 1);

  state_e              state_r;
  state_e              state_s;
  mode_e               mode_r;
  mode_e               cmd_mode_s;
  logic [WCNT_W-1:0]   word_cnt_r;
  logic                cmd_ready_r;
  logic                mem_req_r;
  logic                mem_we_r;
  logic [ADDR_W-1:0]   mem_addr_r;
  logic [DATA_W-1:0]   mem_wdata_r;
  logic [DATA_W-1:0]   rd_data_r;
  logic                done_r;
  logic                error_r;
  logic                accept_s;
  logic                abort_s;
  logic                load_rd_s;
  logic                clr_step_s;
  logic                tmo_clear_s;
  logic                tmo_enable_s;
  logic                tmo_expired_s;

  assign cmd_mode_s = mode_e'(bus.cmd_mode);

  // The wait counter restarts on every state change and every memory ack.
  assign tmo_enable_s = is_mem_wait(state_r);
  assign tmo_clear_s  = (state_s != state_r) || bus.mem_ack;

  mem_timeout_cnt #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (tmo_clear_s),
    .enable  (tmo_enable_s),
    .expired (tmo_expired_s)
  );

  // State register; reset drops the sequencer into IDLE immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode plus the single-cycle events that steer the datapath.
  always_comb begin
    state_s    = state_r;
    accept_s   = 1'b0;
    abort_s    = 1'b0;
    load_rd_s  = 1'b0;
    clr_step_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept_s = 1'b1;
          case (cmd_mode_s)
            CLEAR:       state_s = CLR_ISSUE;
            READ, WRITE: state_s = ISSUE;
            default: begin
              abort_s = 1'b1;
              state_s = FINISH;
            end
          endcase
        end else begin
          state_s = IDLE;
        end
      end
      ISSUE: begin
        if (bus.mem_ack) begin
          if (mode_r == WRITE) begin
            state_s = FINISH;
          end else if (bus.mem_rvalid) begin
            // Data returned together with the ack: skip the wait state.
            load_rd_s = 1'b1;
            state_s   = FINISH;
          end else begin
            state_s = WAIT_RD;
          end
        end else if (tmo_expired_s) begin
          abort_s = 1'b1;
          state_s = FINISH;
        end else begin
          state_s = ISSUE;
        end
      end
      WAIT_RD: begin
        if (bus.mem_rvalid) begin
          load_rd_s = 1'b1;
          state_s   = FINISH;
        end else if (tmo_expired_s) begin
          abort_s = 1'b1;
          state_s = FINISH;
        end else begin
          state_s = WAIT_RD;
        end
      end
      CLR_ISSUE: begin
        if (bus.mem_ack) begin
          clr_step_s = 1'b1;
          if (word_cnt_r == LAST_WORD) begin
            state_s = FINISH;
          end else begin
            state_s = CLR_ISSUE;
          end
        end else if (tmo_expired_s) begin
          abort_s = 1'b1;
          state_s = FINISH;
        end else begin
          state_s = CLR_ISSUE;
        end
      end
      FINISH: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Command latch, memory request registers and status outputs, all loaded
  // from the next state so every bus output comes straight from a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_r      <= CLEAR;
      word_cnt_r  <= '0;
      cmd_ready_r <= 1'b1;
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= '0;
      mem_wdata_r <= '0;
      rd_data_r   <= '0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
    end else begin
      cmd_ready_r <= (state_s == IDLE);
      mem_req_r   <= is_req_state(state_s);
      done_r      <= (state_s == FINISH);
      if (accept_s) begin
        mode_r      <= cmd_mode_s;
        mem_addr_r  <= bus.cmd_addr;
        mem_we_r    <= (cmd_mode_s == CLEAR) || (cmd_mode_s == WRITE);
        mem_wdata_r <= (cmd_mode_s == WRITE) ? bus.cmd_wdata : '0;
        word_cnt_r  <= '0;
        // An illegal mode aborts at once; anything else starts error-free.
        error_r     <= abort_s;
      end else begin
        if (clr_step_s) begin
          // Natural ADDR_W-bit overflow gives the wrap to address zero.
          mem_addr_r <= mem_addr_r + ADDR_W'(1);
          word_cnt_r <= word_cnt_r + WCNT_W'(1);
        end
        if (abort_s) begin
          error_r <= 1'b1;
        end
      end
      if (load_rd_s) begin
        rd_data_r <= bus.mem_rdata;
      end
    end
  end

  assign bus.cmd_ready = cmd_ready_r;
  assign bus.mem_req   = mem_req_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = mem_addr_r;
  assign bus.mem_wdata = mem_wdata_r;
  assign bus.rd_data   = rd_data_r;
  assign bus.done      = done_r;
  assign bus.error     = error_r;
endmodule

// File: tb/tb_mem_access_sequencer.sv
// Bench for mem_access_sequencer: directed commands, a transaction-level
// model (expected request queue, expected completions, read-data and error
// bookkeeping) checked on every falling edge, plus literal spot checks.
module tb_mem_access_sequencer;
  localparam int AW = 25;
  localparam int DW = 16;
  localparam int CW = 4;
  localparam int TO = 8;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  logic clk;
  logic rst;

  mem_access_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  mem_access_sequencer #(
    .ADDR_W(AW), .DATA_W(DW), .CLEAR_WORDS(CW), .TIMEOUT(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state.
  req_t          exp_q[$];
  logic          exp_done_q[$];
  logic          chk_en       = 1'b0;
  logic          busy         = 1'b0;
  logic          read_pending = 1'b0;
  logic          model_err    = 1'b0;
  logic [DW-1:0] model_rd     = '0;
  int            wait_cnt     = 0;
  int            req_run      = 0;
  int            last_run     = 0;
  int            ncyc         = 0;
  int            accept_cyc   = 0;
  int            done_cyc     = 0;
  int            done_cnt     = 0;
  int            hs_n         = 0;
  logic [AW-1:0] hs_addr [16];
  int            hs_cyc  [16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Per-cycle comparison of the DUT against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      logic accept;
      logic exp_mreq;
      logic exp_e;
      ncyc++;
      accept = bus.cmd_valid && !busy;
      check("cmd_ready", 32'(bus.cmd_ready), 32'(!busy));
      check("rd_data", 32'(bus.rd_data), 32'(model_rd));
      // A request is outstanding until acked, unless TIMEOUT waits elapsed.
      exp_mreq = busy && (exp_q.size() != 0) && (wait_cnt < TO);
      check("mem_req", 32'(bus.mem_req), 32'(exp_mreq));
      if (bus.mem_req && exp_q.size() != 0) begin
        check("mem_we", 32'(bus.mem_we), 32'(exp_q[0].we));
        check("mem_addr", 32'(bus.mem_addr), 32'(exp_q[0].addr));
        if (exp_q[0].we) check("mem_wdata", 32'(bus.mem_wdata), 32'(exp_q[0].wdata));
      end
      if (bus.mem_req && bus.mem_ack) begin
        if (hs_n < 16) begin
          hs_addr[hs_n] = bus.mem_addr;
          hs_cyc[hs_n]  = ncyc;
        end
        hs_n++;
        if (exp_q.size() != 0) begin
          if (!exp_q[0].we) read_pending = 1'b1;
          exp_q.delete(0);
        end
        wait_cnt = 0;
      end else if (bus.mem_req) begin
        wait_cnt++;
      end
      if (read_pending && bus.mem_rvalid) begin
        model_rd     = bus.mem_rdata;
        read_pending = 1'b0;
      end
      if (bus.mem_req) begin
        req_run++;
      end else begin
        if (req_run != 0) last_run = req_run;
        req_run = 0;
      end
      if (bus.done) begin
        check("done_expected", 32'(bus.done), 32'(busy && exp_done_q.size() != 0));
        if (exp_done_q.size() != 0) begin
          exp_e = exp_done_q.pop_front();
          check("error_at_done", 32'(bus.error), 32'(exp_e));
          if (!exp_e) check("reqs_left_at_done", 32'(exp_q.size()), 32'd0);
          model_err = exp_e;
        end
        exp_q.delete();
        read_pending = 1'b0;
        busy         = 1'b0;
        done_cyc     = ncyc;
        done_cnt++;
      end else begin
        check("error", 32'(bus.error), 32'(model_err));
      end
      if (accept) begin
        busy       = 1'b1;
        model_err  = 1'b0;
        wait_cnt   = 0;
        accept_cyc = ncyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] mode, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
    int n = 0;
    while (busy && n < 50) begin
      tick();
      n++;
    end
    check("ready_before_cmd", 32'(bus.cmd_ready), 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = mode;
    bus.cmd_addr  = addr;
    bus.cmd_wdata = wdata;
    tick();
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int start = done_cnt;
    int n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    check("done_seen", 32'(done_cnt > start), 32'd1);
  endtask

  task automatic push_req(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    req_t r;
    r.we = we;
    r.addr = addr;
    r.wdata = wdata;
    exp_q.push_back(r);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] start_a;
    bus.cmd_valid  = 1'b0;
    bus.cmd_mode   = 2'b00;
    bus.cmd_addr   = '0;
    bus.cmd_wdata  = '0;
    bus.mem_ack    = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    // Reset state.
    check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_rd_data", 32'(bus.rd_data), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_error", 32'(bus.error), 32'd0);
    rst = 1'b0;
    chk_en = 1'b1;

    // Write with immediate ack.
    push_req(1'b1, 25'h0001234, 16'hBEEF);
    exp_done_q.push_back(1'b0);
    send_cmd(2'b10, 25'h0001234, 16'hBEEF);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    wait_done(20);
    check("wr_done_latency", 32'(done_cyc - accept_cyc), 32'd2);
    check("wr_error", 32'(bus.error), 32'd0);

    // Read, ack delayed 3 cycles, data 2 cycles after the ack.
    push_req(1'b0, 25'h1FFFFFF, 16'h0000);
    exp_done_q.push_back(1'b0);
    send_cmd(2'b01, 25'h1FFFFFF, 16'h0000);
    repeat (3) tick();
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    tick();
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'hA5A5;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;
    check("rd_done_timing", 32'(bus.done), 32'd1);
    check("rd_data_lit", 32'(bus.rd_data), 32'h0000A5A5);
    wait_done(20);

    // Clear across the top of the address space.
    hs_n = 0;
    start_a = 25'h1FFFFFE;
    for (int i = 0; i < CW; i++) push_req(1'b1, AW'((32'(start_a) + i) % (32'd1 << AW)), '0);
    exp_done_q.push_back(1'b0);
    send_cmd(2'b00, start_a, 16'hFFFF);
    bus.mem_ack = 1'b1;
    wait_done(30);
    bus.mem_ack = 1'b0;
    check("clr_count", 32'(hs_n), 32'd4);
    check("clr_addr0", 32'(hs_addr[0]), 32'h01FFFFFE);
    check("clr_addr1", 32'(hs_addr[1]), 32'h01FFFFFF);
    check("clr_addr2", 32'(hs_addr[2]), 32'h00000000);
    check("clr_addr3", 32'(hs_addr[3]), 32'h00000001);
    check("clr_back_to_back", 32'(hs_cyc[3] - hs_cyc[0]), 32'd3);

    // Timeout: no ack ever.
    push_req(1'b1, 25'h0000ABC, 16'h5555);
    exp_done_q.push_back(1'b1);
    send_cmd(2'b10, 25'h0000ABC, 16'h5555);
    wait_done(40);
    check("tmo_req_cycles", 32'(last_run), 32'd8);
    check("tmo_error_sticky", 32'(bus.error), 32'd1);
    push_req(1'b1, 25'h0000002, 16'h0001);
    exp_done_q.push_back(1'b0);
    send_cmd(2'b10, 25'h0000002, 16'h0001);
    check("err_cleared_on_accept", 32'(bus.error), 32'd0);
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    wait_done(20);

    // Illegal mode, then stray read data while idle.
    exp_done_q.push_back(1'b1);
    send_cmd(2'b11, 25'h0000055, 16'h7777);
    wait_done(20);
    check("ill_error", 32'(bus.error), 32'd1);
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 16'h1234;
    tick();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 16'h0000;
    tick();
    check("stray_rvalid", 32'(bus.rd_data), 32'h0000A5A5);

    // Reset in the middle of a clear.
    start_a = 25'h0000100;
    for (int i = 0; i < CW; i++) push_req(1'b1, AW'(32'(start_a) + i), '0);
    exp_done_q.push_back(1'b0);
    send_cmd(2'b00, start_a, 16'h0000);
    bus.mem_ack = 1'b1;
    tick();
    #1;
    check("clr_req_before_rst", 32'(bus.mem_req), 32'd1);
    chk_en = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_async_req", 32'(bus.mem_req), 32'd0);
    check("rst_async_done", 32'(bus.done), 32'd0);
    bus.mem_ack = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    exp_done_q.delete();
    busy = 1'b0;
    read_pending = 1'b0;
    model_err = 1'b0;
    model_rd = '0;
    wait_cnt = 0;
    req_run = 0;
    chk_en = 1'b1;
    @(negedge clk);
    #1;
    check("ready_after_rst", 32'(bus.cmd_ready), 32'd1);
    check("rd_data_after_rst", 32'(bus.rd_data), 32'd0);
    repeat (5) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter ADDR_W, 25, memory word-address width.
REQ-002 Parameter DATA_W, 16, memory data width.
REQ-003 Parameter CLEAR_WORDS, 1024, words written per clear command (legal range 1..2^ADDR_W).
REQ-004 Parameter TIMEOUT, 255, maximum cycles spent waiting on the memory before an abort.
REQ-005 clk  in  1  single system clock; all state updates on its rising edge.
REQ-006 rst  in  1  reset, asynchronous and active-high.
REQ-007 cmd_valid  in  1  front-end command strobe.
REQ-008 cmd_ready  out  1  sequencer idle, command accepted when cmd_valid & cmd_ready.
REQ-009 cmd_mode  in  2  00 clear, 01 read, 10 write, 11 illegal.
REQ-010 cmd_addr  in  ADDR_W  target address, or start address for clear.
REQ-011 cmd_wdata  in  DATA_W  write data.
REQ-012 mem_req / mem_we  out  1 / 1  memory request and write-enable.
REQ-013 mem_addr / mem_wdata  out  ADDR_W / DATA_W  request address and data.
REQ-014 mem_ack  in  1  memory accepts the request this cycle.
REQ-015 mem_rvalid / mem_rdata  in  1 / DATA_W  read-return strobe and data.
REQ-016 rd_data  out  DATA_W  last successfully read word, held for display.
REQ-017 done  out  1  one-cycle completion pulse.
REQ-018 error  out  1  sticky abort flag, set with done and cleared when the next command is accepted.

Function
REQ-019 FSM states SHALL be IDLE, ISSUE, WAIT_RD, CLR_ISSUE, FINISH.
REQ-020 cmd_ready SHALL be 1 only in IDLE.
REQ-021 On acceptance the sequencer SHALL latch mode, address and data, clear error, and go to ISSUE (read/write), CLR_ISSUE (clear) or FINISH with error=1 (mode 11, no memory access).
REQ-022 mem_req SHALL be 1 in ISSUE and CLR_ISSUE; mem_we, mem_addr and mem_wdata SHALL stay stable while mem_req=1 and mem_ack=0.
REQ-023 ISSUE with mem_ack: write goes to FINISH; read goes to WAIT_RD, or straight to FINISH if mem_rvalid is also 1 that cycle.
REQ-024 WAIT_RD: the first mem_rvalid SHALL load rd_data from mem_rdata and go to FINISH; mem_rvalid outside read states SHALL be ignored.
REQ-025 Clear SHALL issue CLEAR_WORDS writes of zero (mem_we=1, mem_wdata=0) at consecutive addresses starting at cmd_addr.
REQ-026 The clear address SHALL wrap from 2^ADDR_W-1 to 0.
REQ-027 The clear word counter SHALL advance only on mem_ack; after the last ack the sequencer SHALL go to FINISH, with no idle cycle between consecutive clear requests.
REQ-028 A timeout counter SHALL reset on every state change and every mem_ack, and count cycles spent in ISSUE, CLR_ISSUE and WAIT_RD.
REQ-029 When the timeout counter reaches TIMEOUT, the sequencer SHALL drop mem_req the next cycle, set error=1 and go to FINISH.
REQ-030 FINISH SHALL assert done for exactly one cycle, then return to IDLE.
REQ-031 Command latency: a write with an immediate ack SHALL produce done 2 cycles after acceptance; cmd_ready SHALL return the cycle after done.

Reset
REQ-032 Asserting rst SHALL immediately (asynchronously) force state to IDLE.
REQ-033 Asserting rst SHALL force mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rd_data=0, done=0, error=0, and clear all counters.
REQ-034 Reset in the middle of a command SHALL abandon it with no done pulse; cmd_ready SHALL be 1 on the first edge after rst deasserts.

Structure
REQ-035 A shared package mem_ctrl_pkg SHALL hold the mode encodings (CLEAR, READ, WRITE), the FSM state enum, and the ADDR_W/DATA_W defaults for reuse by the front-end and display logic.
REQ-036 The timeout counter SHALL be a sub-module, mem_timeout_cnt, with inputs clear and enable and output expired.

Verification
REQ-037 Write test: write addr 0x0001234, data 0xBEEF, mem_ack on the first cycle -> one request with mem_we=1 and the matching addr/data, done 2 cycles after acceptance, error=0.
REQ-038 Read test: read addr 0x1FFFFFF, mem_ack delayed 3 cycles, mem_rvalid 2 cycles later with 0xA5A5 -> rd_data=0xA5A5, done 1 cycle later.
REQ-039 Clear wrap test: CLEAR_WORDS=4, start address 0x1FFFFFE, ack every cycle -> zero writes to 1FFFFFE, 1FFFFFF, 0000000, 0000001, then one done pulse.
REQ-040 Timeout test: TIMEOUT=8, mem_ack never asserted -> mem_req high for 8 cycles then dropped, done pulse with error=1, a following command clears error.
REQ-041 Illegal mode and stray data test: mode 11 -> no mem_req, done with error=1; mem_rvalid while IDLE -> rd_data unchanged.
REQ-042 Reset test: rst asserted during the 2nd word of a clear -> mem_req=0 without waiting for a clock edge, no done pulse, cmd_ready=1 after release.
